// File: rtl/rev_pkg.sv
// Shared definitions for the reversible-gate ALU: gate select encoding.
package rev_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    FEYNMAN   = 2'd0,
    TOFFOLI   = 2'd1,
    PERES     = 2'd2,
    PERES_INV = 2'd3
  } op_e;

endpackage

// File: rtl/rev_gate_core.sv
// Per-bit reversible gate equations, fed with the stage-1 partial terms a, a^b, a&b, c.
module rev_gate_core
  import rev_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] axb,
  input  logic [WIDTH-1:0] anb,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    p = a;
    q = axb;
    r = c;
    case (op)
      FEYNMAN: ;
      // b is recovered from the registered a^b so stage 1 need not carry b itself
      TOFFOLI: begin
        q = a ^ axb;
        r = anb ^ c;
      end
      PERES:     r = anb ^ c;
      PERES_INV: r = c ^ (a & axb);
      default: ;
    endcase
  end

endmodule

// File: rtl/rtl_rev_alu.sv
// Two-stage reversible-gate ALU with valid/ready flow control.
// Optional registered parity output par when REV_PARITY_EN is defined.
module rtl_rev_alu
  import rev_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [OP_W-1:0]  op_out
`ifdef REV_PARITY_EN
  ,
  output logic             par
`endif
);

  logic             en;
  logic             vld_p1, vld_p2;
  op_e              op_p1;
  logic [WIDTH-1:0] a_p1, axb_p1, anb_p1, c_p1;
  logic [WIDTH-1:0] p_p2, q_p2, r_p2;
  logic [OP_W-1:0]  op_p2;
  logic [WIDTH-1:0] gp, gq, gr;

  // The whole pipe moves together: it advances whenever the output slot is free or being taken.
  assign en       = !vld_p2 || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: operand capture and partial terms ----
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      op_p1  <= op_e'(op);
      a_p1   <= a;
      axb_p1 <= a ^ b;
      anb_p1 <= a & b;
      c_p1   <= c;
    end
  end

  rev_gate_core #(.WIDTH(WIDTH)) u_core (
    .op  (op_p1),
    .a   (a_p1),
    .axb (axb_p1),
    .anb (anb_p1),
    .c   (c_p1),
    .p   (gp),
    .q   (gq),
    .r   (gr)
  );

  // ---- stage 2: gate results ----
  always_ff @(posedge clk) begin
    if (rst) begin
      p_p2  <= '0;
      q_p2  <= '0;
      r_p2  <= '0;
      op_p2 <= '0;
    end else if (en && vld_p1) begin
      p_p2  <= gp;
      q_p2  <= gq;
      r_p2  <= gr;
      op_p2 <= op_p1;
    end
  end

`ifdef REV_PARITY_EN
  logic par_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_p2 <= 1'b0;
    end else if (en && vld_p1) begin
      par_p2 <= ^{gp, gq, gr};
    end
  end

  assign par = par_p2;
`endif

  assign out_valid = vld_p2;
  assign p         = p_p2;
  assign q         = q_p2;
  assign r         = r_p2;
  assign op_out    = op_p2;

endmodule

// File: tb/tb_rtl_rev_alu.sv
// Randomized and directed bench for rtl_rev_alu against a queue-based reference model.
module tb_rtl_rev_alu;
  import rev_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op, op_out;
  logic [31:0] a, b, c, p, q, r;

  logic        in_valid8, in_ready8, out_valid8;
  logic [1:0]  op8, op_out8;
  logic [7:0]  a8, b8, c8, p8, q8, r8;
`ifdef REV_PARITY_EN
  logic        par, par8;
`endif

  always #5 clk = ~clk;

  rtl_rev_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .q(q), .r(r), .op_out(op_out)
`ifdef REV_PARITY_EN
    , .par(par)
`endif
  );

  rtl_rev_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .c(c8), .out_valid(out_valid8), .out_ready(1'b1),
    .p(p8), .q(q8), .r(r8), .op_out(op_out8)
`ifdef REV_PARITY_EN
    , .par(par8)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] p, q, r;
    logic        par;
  } res_t;

  res_t exp_q[$];
  res_t prev;
  logic hold_prev = 1'b0;
  int   n_tests = 0, n_fail = 0, n_pop = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t gate_ref(input logic [1:0] o, input logic [31:0] x, y, z);
    res_t t;
    t.op = o;
    t.p  = x;
    case (o)
      2'd0:    begin t.q = x ^ y; t.r = z;                 end
      2'd1:    begin t.q = y;     t.r = (x & y) ^ z;       end
      2'd2:    begin t.q = x ^ y; t.r = (x & y) ^ z;       end
      default: begin t.q = x ^ y; t.r = z ^ (x & (x ^ y)); end
    endcase
    t.par = ^{t.p, t.q, t.r};
    return t;
  endfunction

  // One clock: called at a falling edge with inputs already driven.
  task automatic cyc();
    res_t e;
    #1;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_p", p, prev.p);
        check("hold_q", q, prev.q);
        check("hold_r", r, prev.r);
        check("hold_op", op_out, prev.op);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("res_op", op_out, e.op);
          check("res_p", p, e.p);
          check("res_q", q, e.q);
          check("res_r", r, e.r);
`ifdef REV_PARITY_EN
          check("res_par", par, e.par);
`endif
        end
      end
      hold_prev = out_valid && !out_ready;
      prev.op = op_out;
      prev.p  = p;
      prev.q  = q;
      prev.r  = r;
      if (in_valid && in_ready) exp_q.push_back(gate_ref(op, a, b, c));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lat_test(input string tag, input logic [1:0] o,
                          input logic [31:0] ai, bi, ci, ep, eq, er,
                          output logic [31:0] gp, gq, gr);
    op = o; a = ai; b = bi; c = ci; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check({tag, "_early_valid"}, out_valid, 0);
    cyc();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_p"}, p, ep);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_op"}, op_out, o);
    gp = p; gq = q; gr = r;
  endtask

  initial begin
    logic [31:0] tp, tq, tr, ra, rb, rc;
    res_t        t, items[6];
    int          sent, pops0;
    logic        acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0; c = '0;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; c8 = '0;
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_op_out", op_out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst8_in_ready", in_ready8, 1);
    check("rst8_op_out", op_out8, 0);

    // 8-bit instance, FEYNMAN
    op8 = FEYNMAN; a8 = 8'hF0; b8 = 8'h3C; c8 = 8'hAA; in_valid8 = 1'b1;
    cyc();
    in_valid8 = 1'b0;
    cyc();
    check("w8_valid", out_valid8, 1);
    check("w8_p", p8, 8'hF0);
    check("w8_q", q8, 8'hCC);
    check("w8_r", r8, 8'hAA);

    lat_test("peres_a5", PERES, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0,
             32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0, tp, tq, tr);
`ifdef REV_PARITY_EN
    check("peres_a5_par", par, 0);
`endif
    lat_test("toffoli", TOFFOLI, 32'hFFFFFFFF, 32'h12345678, 32'h0F0F0F0F,
             32'hFFFFFFFF, 32'h12345678, 32'h1D3B5977, tp, tq, tr);
    lat_test("peres_fwd", PERES, 32'h12345678, 32'h87654321, 32'h0,
             32'h12345678, 32'h95511559, 32'h02244220, tp, tq, tr);
    lat_test("peres_inv", PERES_INV, 32'h12345678, 32'h95511559, 32'h02244220,
             32'h12345678, 32'h87654321, 32'h0, tp, tq, tr);

    // PERES then PERES_INV must restore the original operands
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      t = gate_ref(2'd2, ra, rb, rc);
      lat_test("rt_fwd", PERES, ra, rb, rc, t.p, t.q, t.r, tp, tq, tr);
      lat_test("rt_inv", PERES_INV, tp, tq, tr, ra, rb, rc, tp, tq, tr);
    end
    cyc();

    // six back-to-back transfers with the consumer stalled on cycles 3..5
    for (int k = 0; k < 6; k++) begin
      items[k].op = 2'($urandom_range(0, 3));
      items[k].p = $urandom; items[k].q = $urandom; items[k].r = $urandom;
    end
    sent = 0;
    pops0 = n_pop;
    for (int t2 = 0; t2 < 16; t2++) begin
      out_ready = !(t2 >= 3 && t2 <= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        op = items[sent].op; a = items[sent].p; b = items[sent].q; c = items[sent].r;
      end
      #1;
      if (t2 >= 3 && t2 <= 5) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
      end
      acc = in_valid && in_ready;
      cyc();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_sent", sent, 6);
    check("stall_results", n_pop - pops0, 6);

    // reset with two entries in flight; the transfer offered during reset must be dropped
    for (int k = 0; k < 2; k++) begin
      op = TOFFOLI; a = $urandom; b = $urandom; c = $urandom; in_valid = 1'b1;
      cyc();
    end
    rst = 1'b1; op = PERES; a = 32'hDEADBEEF;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_p", p, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      check("no_stale", out_valid, 0);
      cyc();
    end

    // random traffic with random back-pressure
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom; c = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtl_rev_alu.md
RTL_REV_ALU -- requirements
Module: rtl_rev_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result bit width (legal range 1..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand set is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-006 SHALL have port op, input, 2 bits: gate select (0 FEYNMAN, 1 TOFFOLI, 2 PERES, 3 PERES_INV).
REQ-007 SHALL have ports a, b, c, each input, WIDTH bits: gate operands.
REQ-008 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 SHALL have ports p, q, r, each output, WIDTH bits: gate results.
REQ-011 SHALL have port op_out, output, 2 bits: the op that produced p, q and r.

Function
REQ-012 SHALL apply each gate bitwise across all WIDTH bits:
- FEYNMAN: p=a, q=a^b, r=c.
- TOFFOLI: p=a, q=b, r=(a&b)^c.
- PERES: p=a, q=a^b, r=(a&b)^c.
- PERES_INV: p=a, q=a^b, r=c^(a&(a^b)).
REQ-013 SHALL be a two-stage pipeline:
- Stage 1 registers op, a, a^b, a&b and c.
- Stage 2 registers p, q, r and op_out.
REQ-014 SHALL define en = !out_valid || out_ready, drive in_ready = en, and advance both stages only when en=1.
REQ-015 SHALL accept a transfer when in_valid && in_ready; without stall, its result appears with out_valid=1 exactly 2 cycles after acceptance.
REQ-016 SHALL hold p, q, r, op_out and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL propagate bubbles (in_valid=0 while en=1) as invalid stage entries; bubbles are not collapsed.
REQ-018 SHALL deliver results in acceptance order, with no loss or duplication, under any in_valid/out_ready pattern.
REQ-019 SHALL, when a transfer and a result take occur in the same cycle, complete both in that cycle (full throughput of 1 per cycle).
REQ-020 SHALL, for PERES followed by PERES_INV on (p, q, r), return the original (a, b, c).

Reset
REQ-021 SHALL, on rst=1 at a clock edge, clear both stage valid bits, out_valid, p, q, r and op_out to 0; in_ready is then 1.
REQ-022 SHALL, on rst mid-operation, discard in-flight data; a transfer presented in the reset cycle is not accepted.

Configuration
REQ-023 SHALL, with macro REV_PARITY_EN defined, add output port par (1 bit), registered in stage 2 with value ^{p,q,r}, reset to 0 and held under stall like p.
REQ-024 SHALL, without REV_PARITY_EN, have no par port and no parity logic.

Structure
REQ-025 SHALL use shared package rev_pkg containing the op enum (FEYNMAN, TOFFOLI, PERES, PERES_INV) and OP_W=2.
REQ-026 SHALL implement the per-bit gate equations in one combinational sub-module, rev_gate_core, parameterised by WIDTH.

Verification
REQ-027 SHALL cover: PERES, a=A5A5A5A5, b=5A5A5A5A, c=0 -> 2 cycles later p=A5A5A5A5, q=FFFFFFFF, r=00000000 (par=0 if enabled).
REQ-028 SHALL cover: TOFFOLI, a=FFFFFFFF, b=12345678, c=0F0F0F0F -> p=FFFFFFFF, q=12345678, r=1D3B5977.
REQ-029 SHALL cover: PERES on a=12345678, b=87654321, c=0 -> q=95511559, r=02244220; feeding (12345678, 95511559, 02244220) with PERES_INV -> q=87654321, r=00000000.
REQ-030 SHALL cover: 6 back-to-back transfers with out_ready=0 for cycles 3-5 -> in_ready=0 while stalled, outputs frozen, all 6 results emerge in order.
REQ-031 SHALL cover: rst=1 with 2 entries in flight -> next cycle out_valid=0, p=q=r=0, in_ready=1, and no stale result appears afterwards.
REQ-032 SHALL cover: WIDTH=8, FEYNMAN, a=F0, b=3C, c=AA -> p=F0, q=CC, r=AA.
